// File: rtl/mem_loader.sv
// mem_loader: copies a block of words from an SDRAM read port into an
// on-chip memory, one read/write pair per word. Addresses wrap at their
// natural widths; a stalled read is abandoned after TIMEOUT cycles.
// Optionally starts a fixed transfer on the first clock after reset.
module mem_loader #(
    parameter int                  DATA_W     = 128,
    parameter int                  SDRAM_AW   = 22,
    parameter int                  MEM_AW     = 9,
    parameter int                  TIMEOUT    = 1023,
    parameter bit                  AUTO_START = 1'b1,
    parameter logic [SDRAM_AW-1:0] AUTO_SRC   = 22'h31E000,
    parameter logic [MEM_AW-1:0]   AUTO_DST   = 9'h000,
    parameter logic [MEM_AW:0]     AUTO_COUNT = 10'd256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [SDRAM_AW-1:0] src_base,
    input  logic [MEM_AW-1:0]   dst_base,
    input  logic [MEM_AW:0]     word_count,
    input  logic                sdram_wait,
    input  logic                sdram_ack,
    input  logic [DATA_W-1:0]   sdram_data,
    output logic                sdram_rd,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                mem_wr,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [MEM_AW:0]     words_done
);

    // Timer only has to hold values up to TIMEOUT-1.
    localparam int TMR_W = ($clog2(TIMEOUT) < 2) ? 2 : $clog2(TIMEOUT);

    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]    TMR_ZERO   = TMR_W'(0);
    localparam logic [TMR_W-1:0]    TMR_ONE    = TMR_W'(1);
    localparam logic [SDRAM_AW-1:0] SRC_ONE    = SDRAM_AW'(1);
    localparam logic [MEM_AW-1:0]   DST_ONE    = MEM_AW'(1);
    localparam logic [MEM_AW:0]     CNT_ZERO   = (MEM_AW + 1)'(0);
    localparam logic [MEM_AW:0]     CNT_ONE    = (MEM_AW + 1)'(1);
    localparam logic [MEM_AW:0]     CNT_FULL   = (MEM_AW + 1)'(1) << MEM_AW;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [SDRAM_AW-1:0]   src_r;
    logic [SDRAM_AW-1:0]   src_nx_s;
    logic [MEM_AW-1:0]     dst_r;
    logic [MEM_AW-1:0]     dst_nx_s;
    logic [MEM_AW:0]       count_r;
    logic [MEM_AW:0]       count_nx_s;
    logic [MEM_AW:0]       words_done_r;
    logic [MEM_AW:0]       words_done_nx_s;
    logic [TMR_W-1:0]      timer_r;
    logic [TMR_W-1:0]      timer_nx_s;
    logic [DATA_W-1:0]     data_r;
    logic [DATA_W-1:0]     data_nx_s;
    logic                  auto_pend_r;
    logic                  go_s;
    logic [SDRAM_AW-1:0]   req_src_s;
    logic [MEM_AW-1:0]     req_dst_s;
    logic [MEM_AW:0]       req_count_s;
    logic                  rd_r;
    logic                  wr_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;

    // A request larger than the memory is limited to one full memory image.
    function automatic logic [MEM_AW:0] clamp_count(input logic [MEM_AW:0] c);
        if (c[MEM_AW]) begin
            return CNT_FULL;
        end else begin
            return c;
        end
    endfunction

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_nx_s      = state_r;
        src_nx_s        = src_r;
        dst_nx_s        = dst_r;
        count_nx_s      = count_r;
        words_done_nx_s = words_done_r;
        timer_nx_s      = timer_r;
        data_nx_s       = data_r;
        go_s            = start | auto_pend_r;
        req_src_s       = auto_pend_r ? AUTO_SRC : src_base;
        req_dst_s       = auto_pend_r ? AUTO_DST : dst_base;
        req_count_s     = clamp_count(auto_pend_r ? AUTO_COUNT : word_count);
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (go_s) begin
                    src_nx_s        = req_src_s;
                    dst_nx_s        = req_dst_s;
                    count_nx_s      = req_count_s;
                    words_done_nx_s = CNT_ZERO;
                    if (req_count_s == CNT_ZERO) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = WAIT_RDY;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            WAIT_RDY: begin
                if (!sdram_wait) begin
                    state_nx_s = READ;
                    timer_nx_s = TMR_ZERO;
                end else begin
                    state_nx_s = WAIT_RDY;
                end
            end
            READ: begin
                if (sdram_ack) begin
                    data_nx_s  = sdram_data;
                    state_nx_s = WRITE;
                end else if (timer_r == TMR_LAST) begin
                    state_nx_s = ERROR;
                end else begin
                    timer_nx_s = timer_r + TMR_ONE;
                end
            end
            WRITE: begin
                src_nx_s        = src_r + SRC_ONE;
                dst_nx_s        = dst_r + DST_ONE;
                words_done_nx_s = words_done_r + CNT_ONE;
                if ((words_done_r + CNT_ONE) == count_r) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = READ;
                    timer_nx_s = TMR_ZERO;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Transfer datapath: addresses, counts, timeout timer and write data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_r        <= {SDRAM_AW{1'b0}};
            dst_r        <= {MEM_AW{1'b0}};
            count_r      <= CNT_ZERO;
            words_done_r <= CNT_ZERO;
            timer_r      <= TMR_ZERO;
            data_r       <= {DATA_W{1'b0}};
        end else begin
            src_r        <= src_nx_s;
            dst_r        <= dst_nx_s;
            count_r      <= count_nx_s;
            words_done_r <= words_done_nx_s;
            timer_r      <= timer_nx_s;
            data_r       <= data_nx_s;
        end
    end

    // The self-start request is live only for the first edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend_r <= AUTO_START;
        end else begin
            auto_pend_r <= 1'b0;
        end
    end

    // Status and strobe outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            rd_r    <= (state_nx_s == READ);
            wr_r    <= (state_nx_s == WRITE);
            busy_r  <= (state_nx_s == WAIT_RDY) || (state_nx_s == READ) ||
                       (state_nx_s == WRITE);
            done_r  <= (state_nx_s == DONE);
            error_r <= (state_nx_s == ERROR);
        end
    end

    assign sdram_rd   = rd_r;
    assign sdram_addr = src_r;
    assign mem_wr     = wr_r;
    assign mem_addr   = dst_r;
    assign mem_data   = data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign words_done = words_done_r;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: an SDRAM responder returns address-derived data,
// a scoreboard queue holds the expected read addresses and memory writes.
module tb_mem_loader;

    typedef struct packed {
        logic [8:0]   addr;
        logic [127:0] data;
    } wr_exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         reset_n_a;
    logic         start;
    logic         start_a;
    logic [21:0]  src_base;
    logic [8:0]   dst_base;
    logic [9:0]   word_count;
    logic         sdram_wait;
    logic         sdram_ack;
    logic [127:0] sdram_data;

    logic         sdram_rd, a_sdram_rd;
    logic [21:0]  sdram_addr, a_sdram_addr;
    logic         mem_wr, a_mem_wr;
    logic [8:0]   mem_addr, a_mem_addr;
    logic [127:0] mem_data, a_mem_data;
    logic         busy, a_busy;
    logic         done, a_done;
    logic         error, a_error;
    logic [9:0]   words_done, a_words_done;

    logic         sel_a;
    logic         m_rd, m_wr;
    logic [21:0]  m_addr;
    logic [8:0]   m_maddr;
    logic [127:0] m_mdata;

    logic         ack_en;
    logic         rand_dly;
    int           fixed_dly;
    int           dly;

    int           vectors = 0;
    int           miscompares = 0;
    int           wr_seen = 0;
    int           ack_seen = 0;
    int           rd_cycles = 0;

    logic [21:0]  exp_rd_q[$];
    wr_exp_t      exp_wr_q[$];

    always #5 clk = ~clk;

    mem_loader #(.AUTO_START(1'b0), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_base(src_base),
        .dst_base(dst_base), .word_count(word_count), .sdram_wait(sdram_wait),
        .sdram_ack(sdram_ack), .sdram_data(sdram_data), .sdram_rd(sdram_rd),
        .sdram_addr(sdram_addr), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done), .error(error),
        .words_done(words_done)
    );

    mem_loader u_auto (
        .clk(clk), .reset_n(reset_n_a), .start(start_a), .src_base(src_base),
        .dst_base(dst_base), .word_count(word_count), .sdram_wait(sdram_wait),
        .sdram_ack(sdram_ack), .sdram_data(sdram_data), .sdram_rd(a_sdram_rd),
        .sdram_addr(a_sdram_addr), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_data(a_mem_data), .busy(a_busy), .done(a_done), .error(a_error),
        .words_done(a_words_done)
    );

    assign m_rd    = sel_a ? a_sdram_rd   : sdram_rd;
    assign m_addr  = sel_a ? a_sdram_addr : sdram_addr;
    assign m_wr    = sel_a ? a_mem_wr     : mem_wr;
    assign m_maddr = sel_a ? a_mem_addr   : mem_addr;
    assign m_mdata = sel_a ? a_mem_data   : mem_data;

    function automatic logic [127:0] pat(input logic [21:0] a);
        return {a, 10'h2A5, ~a, 10'h15A, a ^ 22'h0F0F0F, 10'h0C3, ~a ^ 22'h333333, 10'h1E1};
    endfunction

    // SDRAM responder: acks a pending read after a fixed or random delay.
    initial begin
        sdram_ack  = 1'b0;
        sdram_data = 128'd0;
        dly        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_en && m_rd && !sdram_ack) begin
                if (dly == 0) begin
                    sdram_ack  = 1'b1;
                    sdram_data = pat(m_addr);
                end else begin
                    dly = dly - 1;
                end
            end else begin
                sdram_ack = 1'b0;
                dly = rand_dly ? int'($urandom_range(10, 0)) : fixed_dly;
            end
        end
    end

    // Scoreboard: every acked read and every memory write is checked in order.
    initial begin
        wr_exp_t we;
        logic [21:0] ea;
        forever begin
            @(negedge clk);
            if (m_rd) rd_cycles++;
            if (m_rd && sdram_ack) begin
                ack_seen++;
                vectors++;
                if (exp_rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected sdram_addr=%h", m_addr);
                end else begin
                    ea = exp_rd_q.pop_front();
                    if (m_addr !== ea) begin
                        miscompares++;
                        $display("FAIL rd_addr got=%h exp=%h", m_addr, ea);
                    end
                end
            end
            if (m_wr) begin
                wr_seen++;
                vectors++;
                if (exp_wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected mem_addr=%h", m_maddr);
                end else begin
                    we = exp_wr_q.pop_front();
                    if (m_maddr !== we.addr || m_mdata !== we.data) begin
                        miscompares++;
                        $display("FAIL wr_word got addr=%h data=%h exp addr=%h data=%h",
                                 m_maddr, m_mdata, we.addr, we.data);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [21:0] s, input logic [8:0] d, input int n);
        logic [21:0] a;
        logic [8:0]  m;
        a = s;
        m = d;
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(a);
            exp_wr_q.push_back({m, pat(a)});
            a = a + 22'd1;
            m = m + 9'd1;
        end
    endtask

    task automatic do_start(input logic [21:0] s, input logic [8:0] d, input logic [9:0] c);
        src_base   = s;
        dst_base   = d;
        word_count = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [173:0] ov;
        repeat (3) @(negedge clk);
        ov = {sdram_rd, sdram_addr, mem_wr, mem_addr, mem_data, busy, done, error, words_done};
        vectors++;
        if (ov !== 174'd0) begin miscompares++; $display("FAIL reset_outputs got=%h exp=0", ov); end
        ov = {a_sdram_rd, a_sdram_addr, a_mem_wr, a_mem_addr, a_mem_data, a_busy, a_done, a_error, a_words_done};
        vectors++;
        if (ov !== 174'd0) begin miscompares++; $display("FAIL reset_outputs_auto got=%h exp=0", ov); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if ({busy, sdram_rd, done, error} !== 4'b0000) begin
            miscompares++;
            $display("FAIL no_auto_idle got busy/rd/done/error=%b exp=0000", {busy, sdram_rd, done, error});
        end
    endtask

    task automatic test_auto();
        int base_wr;
        sel_a = 1'b1; sdram_wait = 1'b1; ack_en = 1'b1; rand_dly = 1'b0; fixed_dly = 1;
        push_exp(22'h31E000, 9'h000, 256);
        base_wr = wr_seen;
        reset_n_a = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_busy !== 1'b1) begin miscompares++; $display("FAIL auto_start_busy got=%b exp=1", a_busy); end
        repeat (19) @(negedge clk);
        vectors++;
        if (a_sdram_rd !== 1'b0) begin miscompares++; $display("FAIL auto_wait_hold rd got=%b exp=0", a_sdram_rd); end
        sdram_wait = 1'b0;
        for (int n = 0; n < 2000 && a_done !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            miscompares++; $display("FAIL auto_done got done=%b busy=%b exp 1/0", a_done, a_busy);
        end
        vectors++;
        if (a_words_done !== 10'd256) begin miscompares++; $display("FAIL auto_words got=%0d exp=256", a_words_done); end
        vectors++;
        if (wr_seen - base_wr != 256 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            miscompares++; $display("FAIL auto_writes got=%0d exp=256 left=%0d", wr_seen - base_wr, exp_wr_q.size());
        end
        sel_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int n;
        fixed_dly = 0;
        push_exp(22'h3FFFFE, 9'h1FE, 4);
        do_start(22'h3FFFFE, 9'h1FE, 10'd4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
        #1;
        vectors++;
        if (n != 10) begin miscompares++; $display("FAIL wrap_latency got=%0d exp=10", n); end
        vectors++;
        if (words_done !== 10'd4 || exp_wr_q.size() != 0) begin
            miscompares++; $display("FAIL wrap_words got=%0d exp=4 left=%0d", words_done, exp_wr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        fixed_dly = 0;
        push_exp(22'h000200, 9'h020, 3);
        do_start(22'h000200, 9'h020, 10'd3);
        for (int n = 0; n < 60 && done !== 1'b1; n++) @(negedge clk);
        push_exp(22'h000300, 9'h030, 3);
        do_start(22'h000300, 9'h030, 10'd3);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_restart got done=%b busy=%b exp 0/1", done, busy);
        end
        for (int n = 0; n < 60 && done !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || words_done !== 10'd3 || exp_wr_q.size() != 0) begin
            miscompares++; $display("FAIL b2b_done got done=%b words=%0d exp 1/3", done, words_done);
        end
    endtask

    task automatic test_busy_start();
        fixed_dly = 2;
        push_exp(22'h001000, 9'h040, 6);
        do_start(22'h001000, 9'h040, 10'd6);
        repeat (5) @(negedge clk);
        do_start(22'h2AAAAA, 9'h100, 10'd2);
        for (int n = 0; n < 100 && done !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || words_done !== 10'd6 || exp_wr_q.size() != 0) begin
            miscompares++; $display("FAIL busy_start_ignored got done=%b words=%0d exp 1/6", done, words_done);
        end
    endtask

    task automatic test_timeout();
        int base_rd, base_wr;
        ack_en = 1'b0;
        base_rd = rd_cycles;
        base_wr = wr_seen;
        do_start(22'h000500, 9'h000, 10'd3);
        for (int n = 0; n < 60 && error !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (rd_cycles - base_rd != 15) begin
            miscompares++; $display("FAIL timeout_cycles got=%0d exp=15", rd_cycles - base_rd);
        end
        vectors++;
        if ({error, sdram_rd, busy, done} !== 4'b1000 || wr_seen != base_wr || words_done !== 10'd0) begin
            miscompares++;
            $display("FAIL timeout_state got err/rd/busy/done=%b writes=%0d words=%0d exp 1000/0/0",
                     {error, sdram_rd, busy, done}, wr_seen - base_wr, words_done);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_zero();
        int base_rd, base_wr;
        base_rd = rd_cycles;
        base_wr = wr_seen;
        do_start(22'h000700, 9'h000, 10'd0);
        @(negedge clk);
        vectors++;
        if ({done, busy, error} !== 3'b100) begin
            miscompares++; $display("FAIL zero_done got done/busy/err=%b exp=100", {done, busy, error});
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (rd_cycles != base_rd || wr_seen != base_wr) begin
            miscompares++; $display("FAIL zero_no_traffic got rd=%0d wr=%0d exp 0/0", rd_cycles - base_rd, wr_seen - base_wr);
        end
    endtask

    task automatic test_reset_mid();
        logic [173:0] ov;
        int base_wr;
        fixed_dly = 3;
        base_wr = wr_seen;
        push_exp(22'h000100, 9'h010, 8);
        do_start(22'h000100, 9'h010, 10'd8);
        for (int n = 0; n < 100 && wr_seen - base_wr < 2; n++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        ov = {sdram_rd, sdram_addr, mem_wr, mem_addr, mem_data, busy, done, error, words_done};
        vectors++;
        if (ov !== 174'd0) begin miscompares++; $display("FAIL midreset_outputs got=%h exp=0", ov); end
        exp_rd_q.delete();
        exp_wr_q.delete();
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (wr_seen - base_wr != 2) begin miscompares++; $display("FAIL midreset_writes got=%0d exp=2", wr_seen - base_wr); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_exp(22'h000100, 9'h010, 8);
        do_start(22'h000100, 9'h010, 10'd8);
        for (int n = 0; n < 200 && done !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || words_done !== 10'd8 || exp_wr_q.size() != 0) begin
            miscompares++; $display("FAIL midreset_rerun got done=%b words=%0d exp 1/8", done, words_done);
        end
    endtask

    task automatic test_random();
        logic [21:0] s;
        logic [8:0]  d;
        int base_wr, base_ack;
        rand_dly = 1'b1;
        s = 22'($urandom);
        d = 9'($urandom);
        base_wr  = wr_seen;
        base_ack = ack_seen;
        push_exp(s, d, 20);
        do_start(s, d, 10'd20);
        for (int n = 0; n < 600 && done !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (wr_seen - base_wr != 20 || ack_seen - base_ack != 20 || words_done !== 10'd20) begin
            miscompares++; $display("FAIL random_counts got wr=%0d ack=%0d words=%0d exp 20", wr_seen - base_wr,
                                    ack_seen - base_ack, words_done);
        end
        rand_dly = 1'b0;
    endtask

    task automatic test_clamp();
        fixed_dly = 0;
        push_exp(22'h3FFF00, 9'h100, 512);
        do_start(22'h3FFF00, 9'h100, 10'd700);
        for (int n = 0; n < 1200 && done !== 1'b1; n++) @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || words_done !== 10'd512 || exp_wr_q.size() != 0) begin
            miscompares++; $display("FAIL clamp_count got done=%b words=%0d exp 1/512", done, words_done);
        end
    endtask

    initial begin
        reset_n = 1'b0; reset_n_a = 1'b0; start = 1'b0; start_a = 1'b0;
        src_base = 22'd0; dst_base = 9'd0; word_count = 10'd0;
        sdram_wait = 1'b0; sel_a = 1'b0; ack_en = 1'b1; rand_dly = 1'b0; fixed_dly = 0;
        test_reset();
        test_auto();
        test_wrap();
        test_back_to_back();
        test_busy_start();
        test_timeout();
        test_zero();
        test_reset_mid();
        test_random();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
